// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU. Holds the opcode
//               encodings, the FSM state type, the result-flag bundle and a
//               helper that identifies multi-cycle operations.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_SHL = 4'b0111;
   localparam logic [3:0] OP_SHR = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic negative;
      logic overflow;
   } flags_t;

   // An all-zero result is the reset result, so zero starts asserted.
   localparam flags_t FLAGS_RESET = '{zero: 1'b1, carry: 1'b0, negative: 1'b0, overflow: 1'b0};

   // Shifts and multiply are handled by the iterative unit.
   function automatic logic is_iter_op(input logic [3:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_MUL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_iter_unit
// Description : Iterative engine for SHL/SHR (one bit per cycle, amount taken
//               from b[SHW-1:0]) and unsigned shift-add multiply (WIDTH
//               iterations). Operands are loaded on start; done is high while
//               the final value is held, for exactly one cycle.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               start             - load operands and begin
//               op, a, b          - operation and operands
//               done              - final result/carry valid this cycle
//               result, carry     - low WIDTH bits and carry per operation
// Revision    : 1.0 - initial release
// ============================================================================
module alu_iter_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   localparam int SHW = $clog2(WIDTH);
   // One extra bit so the counter can hold WIDTH and any shift amount.
   localparam int CW  = SHW + 1;

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic [3:0]           r_op;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mcand;
   logic                 r_sh_carry;
   logic [WIDTH:0]       w_sum;

   // Multiply: r_acc = {partial product, remaining multiplier bits}. Each step
   // conditionally adds the multiplicand to the upper half, then shifts right.
   assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_cnt      <= '0;
         r_op       <= '0;
         r_acc      <= '0;
         r_mcand    <= '0;
         r_sh_carry <= 1'b0;
      end else if (start) begin
         r_busy     <= 1'b1;
         r_op       <= op;
         r_mcand    <= a;
         r_sh_carry <= 1'b0;
         if (op == OP_MUL) begin
            r_acc <= {{WIDTH{1'b0}}, b};
            r_cnt <= CW'(WIDTH);
         end else begin
            r_acc <= {{WIDTH{1'b0}}, a};
            r_cnt <= CW'(b[SHW-1:0]);
         end
      end else if (r_busy) begin
         if (r_cnt == '0) begin
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - CW'(1);
            case (r_op)
               OP_MUL: r_acc <= {w_sum, r_acc[WIDTH-1:1]};
               OP_SHL: begin
                  r_sh_carry         <= r_acc[WIDTH-1];
                  r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], 1'b0};
               end
               OP_SHR: begin
                  r_sh_carry         <= r_acc[0];
                  r_acc[WIDTH-1:0]   <= {1'b0, r_acc[WIDTH-1:1]};
               end
               default: ;
            endcase
         end
      end
   end

   assign done   = r_busy && (r_cnt == '0);
   assign result = r_acc[WIDTH-1:0];
   assign carry  = (r_op == OP_MUL) ? |r_acc[2*WIDTH-1:WIDTH] : r_sh_carry;

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU with valid/ready handshakes on both sides.
//               Operands are captured on acceptance; single-cycle ops finish
//               one cycle later, shifts take k+1 cycles and multiply WIDTH+1.
//               Result and Z/C/N/V flags are registered and held in DONE
//               until the consumer accepts them.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               in_valid, in_ready         - operation handshake
//               opcode, a, b               - operation and operands
//               out_valid, out_ready       - result handshake
//               result                     - WIDTH-bit result
//               zero, carry, negative,
//               overflow                   - result flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow
);

   state_t            r_state, w_state_nx;
   logic [3:0]        r_op;
   logic [WIDTH-1:0]  r_a, r_b;
   logic [WIDTH-1:0]  r_result;
   flags_t            r_flags;

   logic              w_accept, w_load;
   logic              w_iter_done, w_iter_carry;
   logic [WIDTH-1:0]  w_iter_result;
   logic [WIDTH:0]    w_add, w_sub;
   logic [WIDTH-1:0]  w_res;
   logic              w_carry, w_ovf;
   flags_t            w_flags;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign w_accept  = in_valid && in_ready;

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (w_accept && is_iter_op(opcode)),
      .op     (opcode),
      .a      (a),
      .b      (b),
      .done   (w_iter_done),
      .result (w_iter_result),
      .carry  (w_iter_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nx;
   end

   // Every accepted op passes through BUSY; single-cycle ops leave it on the
   // next edge, iterative ops wait for the iterative unit.
   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      case (r_state)
         IDLE: if (w_accept) w_state_nx = BUSY;
         BUSY: begin
            if (!is_iter_op(r_op) || w_iter_done) begin
               w_state_nx = DONE;
               w_load     = 1'b1;
            end
         end
         DONE: if (out_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   // Single-cycle datapath on captured operands, merged with iterative result.
   always_comb begin
      w_add   = {1'b0, r_a} + {1'b0, r_b};
      w_sub   = {1'b0, r_a} - {1'b0, r_b};
      w_res   = r_a;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res   = w_add[WIDTH-1:0];
            w_carry = w_add[WIDTH];
            w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            // The extra bit of the widened difference is the borrow.
            w_res   = w_sub[WIDTH-1:0];
            w_carry = w_sub[WIDTH];
            w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND: w_res = r_a & r_b;
         OP_OR:  w_res = r_a | r_b;
         OP_XOR: w_res = r_a ^ r_b;
         OP_SHL, OP_SHR, OP_MUL: begin
            w_res   = w_iter_result;
            w_carry = w_iter_carry;
         end
         default: ;
      endcase
      w_flags.zero     = (w_res == '0);
      w_flags.carry    = w_carry;
      w_flags.negative = w_res[WIDTH-1];
      w_flags.overflow = w_ovf;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_flags  <= FLAGS_RESET;
      end else begin
         if (w_accept) begin
            r_op <= opcode;
            r_a  <= a;
            r_b  <= b;
         end
         if (w_load) begin
            r_result <= w_res;
            r_flags  <= w_flags;
         end
      end
   end

   assign result   = r_result;
   assign zero     = r_flags.zero;
   assign carry    = r_flags.carry;
   assign negative = r_flags.negative;
   assign overflow = r_flags.overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH=8). A behavioural
//               model predicts result, flags and latency of each accepted
//               operation; a negedge compare process checks the handshake
//               outputs every cycle. Directed ops pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

   localparam int W   = 8;
   localparam int SHW = $clog2(W);

   typedef struct {
      logic [W-1:0] res;
      logic         z, c, n, v;
      int           lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   opcode = 4'h0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero, carry, negative, overflow;

   logic         rand_ready  = 1'b0;
   logic         rnd_ready   = 1'b1;
   logic         ready_force = 1'b1;
   assign out_ready = rand_ready ? rnd_ready : ready_force;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .carry     (carry),
      .negative  (negative),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      #1;
      rnd_ready = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
      exp_t            e;
      longint unsigned ua, ub, full;
      int              k;
      logic [W-1:0]    r;
      ua    = 64'(xa);
      ub    = 64'(xb);
      k     = int'(xb) % (1 << SHW);
      e.c   = 1'b0;
      e.v   = 1'b0;
      e.lat = 1;
      case (op)
         4'h2: begin full = ua + ub; e.c = full[W]; end
         4'h3: begin full = ua - ub; e.c = (ua < ub); end
         4'h4: full = ua & ub;
         4'h5: full = ua | ub;
         4'h6: full = ua ^ ub;
         4'h7: begin full = ua << k; e.c = (k != 0) && full[W]; e.lat = k + 1; end
         4'h8: begin
            full = ua >> k;
            if (k != 0) e.c = ua[k-1];
            e.lat = k + 1;
         end
         4'h9: begin full = ua * ub; e.c = ((full >> W) != 0); e.lat = W + 1; end
         default: full = ua;
      endcase
      r = full[W-1:0];
      if (op == 4'h2) e.v = (xa[W-1] == xb[W-1]) && (r[W-1] != xa[W-1]);
      if (op == 4'h3) e.v = (xa[W-1] != xb[W-1]) && (r[W-1] != xa[W-1]);
      e.res = r;
      e.z   = (r == '0);
      e.n   = r[W-1];
      return e;
   endfunction

   // ---------------- compare process ----------------
   bit   pending = 1'b0;
   int   cyc     = 0;
   int   acc_cyc = 0;
   exp_t m_exp;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         pending = 1'b0;
         check("reset outputs", {in_ready, out_valid, result, zero, carry, negative, overflow},
               {1'b1, 1'b0, 8'h00, 1'b1, 3'b000});
      end else if (pending) begin
         if (cyc - acc_cyc < m_exp.lat + 1) begin
            check("busy handshake", {in_ready, out_valid}, 2'b00);
         end else begin
            check("done handshake", {in_ready, out_valid}, 2'b01);
            check("result", result, m_exp.res);
            check("flags zcnv", {zero, carry, negative, overflow},
                  {m_exp.z, m_exp.c, m_exp.n, m_exp.v});
            if (out_ready) pending = 1'b0;
         end
      end else begin
         check("idle handshake", {in_ready, out_valid}, 2'b10);
         if (in_valid && in_ready) begin
            pending = 1'b1;
            acc_cyc = cyc;
            m_exp   = model(opcode, a, b);
         end
      end
   end

   // ---------------- stimulus helpers (called at posedge + 1) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb);
      int n = 0;
      in_valid = 1'b1;
      opcode   = op;
      a        = xa;
      b        = xb;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         errors++;
         $display("FAIL accept timeout: in_ready stuck 0 for op 0x%0h", op);
      end
      step();
      in_valid = 1'b0;
      opcode   = 4'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (n < 40) begin
         step();
         n++;
         if (out_valid) break;
      end
   endtask

   task automatic run_dir(input string name, input logic [3:0] op, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] er,
                          input logic [3:0] ef, input int elat);
      int n;
      ready_force = 1'b1;
      send(op, xa, xb);
      wait_valid(n);
      check({name, " latency"}, n, elat);
      check({name, " result"}, result, er);
      check({name, " flags"}, {zero, carry, negative, overflow}, ef);
      step();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Directed ops with literal expectations; flags are {Z,C,N,V}
      run_dir("add 7f+01", 4'h2, 8'h7F, 8'h01, 8'h80, 4'b0011, 1);
      run_dir("sub 00-01", 4'h3, 8'h00, 8'h01, 8'hFF, 4'b0110, 1);
      run_dir("and f0&0f", 4'h4, 8'hF0, 8'h0F, 8'h00, 4'b1000, 1);
      run_dir("mul 10*20", 4'h9, 8'h10, 8'h20, 8'h00, 4'b1100, 9);
      run_dir("mul 0d*0b", 4'h9, 8'h0D, 8'h0B, 8'h8F, 4'b0010, 9);
      run_dir("shl 81<<3", 4'h7, 8'h81, 8'h03, 8'h08, 4'b0000, 4);
      run_dir("shr 81>>1", 4'h8, 8'h81, 8'h01, 8'h40, 4'b0100, 2);
      run_dir("shl 81<<0", 4'h7, 8'h81, 8'h00, 8'h81, 4'b0010, 1);
      run_dir("shr 80>>7", 4'h8, 8'h80, 8'hF7, 8'h01, 4'b0000, 8);
      run_dir("xor a5^ff", 4'h6, 8'hA5, 8'hFF, 8'h5A, 4'b0000, 1);
      run_dir("or 00|00",  4'h5, 8'h00, 8'h00, 8'h00, 4'b1000, 1);
      run_dir("pass c3",   4'hF, 8'hC3, 8'h12, 8'hC3, 4'b0010, 1);
      run_dir("sub 80-01", 4'h3, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);
      run_dir("add ff+01", 4'h2, 8'hFF, 8'h01, 8'h00, 4'b1100, 1);

      // Back-pressure: hold DONE, present a new op that must be ignored
      ready_force = 1'b0;
      send(4'h2, 8'h11, 8'h22);
      wait_valid(n);
      in_valid = 1'b1;
      opcode   = 4'h3;
      a        = 8'h50;
      b        = 8'h20;
      repeat (5) begin
         step();
         check("bp hold result", result, 8'h33);
         check("bp hold handshake", {in_ready, out_valid}, 2'b01);
      end
      ready_force = 1'b1;
      step();
      check("bp release idle", {in_ready, out_valid}, 2'b10);
      step();
      check("bp queued accepted", in_ready, 1'b0);
      in_valid = 1'b0;
      wait_valid(n);
      check("bp queued result", result, 8'h30);
      step();

      // Reset during MUL BUSY: outputs must return to reset values at once
      send(4'h9, 8'h37, 8'h5B);
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", {in_ready, out_valid, result, zero, carry, negative, overflow},
            {1'b1, 1'b0, 8'h00, 1'b1, 3'b000});
      step();
      step();
      rst_n = 1'b1;
      step();
      check("post reset idle", {in_ready, out_valid}, 2'b10);
      run_dir("add 02+03", 4'h2, 8'h02, 8'h03, 8'h05, 4'b0000, 1);

      // Randomised traffic with random consumer back-pressure
      rand_ready = 1'b1;
      repeat (250) begin
         repeat ($urandom_range(0, 2)) step();
         send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
      end
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      n = 0;
      while (pending && n < 100) begin
         step();
         n++;
      end
      if (pending) begin
         errors++;
         $display("FAIL drain timeout: result never consumed");
      end
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the processor's 4-bit combinational ALU.
- Accepts one operation per valid/ready handshake and returns a registered result with a full flag set (Z/C/N/V).
- Adds XOR, variable shifts and an iterative shift-add multiply.
- Sits between the register-file read stage and writeback; the control unit throttles on in_ready and out_valid.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 4..32.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept an operation.
- opcode  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; for shifts only b[SHW-1:0] is used.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- carry  output  1  carry/borrow/overflow-of-width, per operation.
- negative  output  1  result[WIDTH-1].
- overflow  output  1  signed overflow (ADD/SUB only).

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous assert, active-low.
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0.
  - result = 0, zero = 1, carry = 0, negative = 0, overflow = 0.
- Opcodes: 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 SHL, 1000 SHR (logical), 1001 MUL (low WIDTH bits). Any other code is PASS (result = a).
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- IDLE:
  - The input is accepted when in_valid && in_ready. a, b and opcode are captured in internal registers.
  - Single-cycle ops (ADD/SUB/AND/OR/XOR/PASS, and SHL/SHR with amount 0) compute from the captured inputs and go to DONE the next cycle. Latency is 1 cycle from acceptance to out_valid.
  - SHL/SHR with amount k > 0 go to BUSY. The shift is one bit per cycle, k cycles, then DONE. Latency is k+1.
  - MUL goes to BUSY for exactly WIDTH shift-add iterations, then DONE. Latency is WIDTH+1.
  - in_valid is ignored outside IDLE. Inputs may change freely after acceptance.
- DONE: result and flags are held stable until out_valid && out_ready. On that handshake the FSM returns to IDLE. The next operation is accepted no earlier than the cycle after.
- Flag rules:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; overflow = a[MSB]==b[MSB] && result[MSB]!=a[MSB].
  - SUB: carry = borrow (a < b, unsigned); overflow = a[MSB]!=b[MSB] && result[MSB]!=a[MSB].
  - SHL: carry = last bit shifted out of the MSB. SHR: carry = last bit shifted out of the LSB. Amount 0 gives carry = 0.
  - MUL: carry = |(upper WIDTH bits of the 2*WIDTH product), unsigned.
  - Logic ops and PASS: carry = 0.
  - overflow = 0 for all ops other than ADD/SUB.
  - zero and negative are always derived from the final result.
- Flags update only on entry to DONE; they are not visible while BUSY.
- Arithmetic is modulo 2^WIDTH. The product register is 2*WIDTH bits internally.
- Reset mid-operation: rst_n low in any state immediately forces all reset values. The in-flight operation is discarded; no partial result is ever presented.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL);
  - the FSM state typedef (IDLE/BUSY/DONE);
  - a flags struct {zero, carry, negative, overflow}.
- One sub-module, alu_iter_unit, is natural. It implements the iterative shift and shift-add multiply: start, op, a, b in; done, result, carry out.
- The top level holds the FSM, the single-cycle datapath, the flag logic and the output registers.

Test Plan:
1. WIDTH=8, ADD a=0x7F b=0x01, out_ready=1 -> out_valid 1 cycle after accept; result=0x80, N=1, V=1, C=0, Z=0.
2. SUB a=0x00 b=0x01 -> result=0xFF, C=1 (borrow), N=1, V=0. Then AND a=0xF0 b=0x0F -> result=0x00, Z=1, C=0.
3. MUL a=0x10 b=0x20 -> out_valid exactly 9 cycles after accept; result=0x00, C=1, Z=1. Then MUL a=0x0D b=0x0B -> result=0x8F, C=0.
4. SHL a=0x81 b=0x03 -> out_valid at cycle 4; result=0x08, C=0. SHR a=0x81 b=0x01 -> result=0x40, C=1. SHL b=0x00 -> latency 1, result=a, C=0.
5. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Releasing out_ready -> IDLE next cycle, then the queued op is accepted.
6. Assert rst_n=0 during MUL BUSY cycle 3 -> all outputs at reset values asynchronously. After release, in_ready=1, out_valid=0, and a fresh ADD 0x02+0x03 returns 0x05.
